// File: rtl/pipe_reg_pkg.sv
// Shared widths, field offsets and state encoding for the ID/EX packer.
// Used by pipe_reg_packer and the execute-stage unpacker.
package pipe_reg_pkg;

  localparam int DATA_W    = 32;
  localparam int CTRL_W    = 54;
  localparam int ALUCTRL_W = 38;
  localparam int BUNDLE_W  =
    4 * DATA_W + CTRL_W + ALUCTRL_W;

  localparam int INST_LSB    = 188;
  localparam int A_LSB       = 156;
  localparam int B_LSB       = 124;
  localparam int CTRL_LSB    = 70;
  localparam int ALUCTRL_LSB = 32;
  localparam int PC_LSB      = 0;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

endpackage

// File: rtl/pipe_reg_slot.sv
// One bundle-wide storage slot of the ID/EX skid buffer.
// Synchronous active-low reset, load enable.
module pipe_reg_slot #(
  parameter int W = 220
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_reg_packer.sv
// ID/EX bundle packer with a two-entry skid buffer and flush.
// Optional perf counters under PIPEREG_PERF_EN.
module pipe_reg_packer #(
  parameter  int DATA_W    = 32,
  parameter  int CTRL_W    = 54,
  parameter  int ALUCTRL_W = 38,
  localparam int BUNDLE_W  =
    4 * DATA_W + CTRL_W + ALUCTRL_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [DATA_W-1:0]    inst,
  input  logic [DATA_W-1:0]    a_data,
  input  logic [DATA_W-1:0]    b_data,
  input  logic [CTRL_W-1:0]    control_data,
  input  logic [ALUCTRL_W-1:0] alucontrol_data,
  input  logic [DATA_W-1:0]    pc,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUNDLE_W-1:0]  dataout
`ifdef PIPEREG_PERF_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [15:0]          flush_drops
`endif
);

  import pipe_reg_pkg::*;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                in_ready_q;
  logic                accept;
  logic                xfer;
  logic                load_main;
  logic                load_skid;
  logic                main_from_skid;
  logic [BUNDLE_W-1:0] bundle_in;
  logic [BUNDLE_W-1:0] main_d;
  logic [BUNDLE_W-1:0] skid_q;

  assign bundle_in = {inst, a_data, b_data,
                      control_data,
                      alucontrol_data, pc};

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign xfer      = out_valid & out_ready;
  assign main_d    = main_from_skid ? skid_q
                                    : bundle_in;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (1'b1)
        (state == EMPTY): begin
          if (accept) begin
            load_main = 1'b1;
            state_nxt = ONE;
          end
        end
        (state == ONE): begin
          if (accept && xfer) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = TWO;
          end else if (xfer) begin
            state_nxt = EMPTY;
          end
        end
        (state == TWO): begin
          if (xfer) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != TWO);
    end
  end

  pipe_reg_slot #(.W(BUNDLE_W)) u_main (
    .clk    (clk),
    .resetn (resetn),
    .load   (load_main),
    .d      (main_d),
    .q      (dataout)
  );

  pipe_reg_slot #(.W(BUNDLE_W)) u_skid (
    .clk    (clk),
    .resetn (resetn),
    .load   (load_skid),
    .d      (bundle_in),
    .q      (skid_q)
  );

`ifdef PIPEREG_PERF_EN
  logic [1:0]  held;
  logic [2:0]  drops;
  logic [16:0] drop_sum;

  // Entries consumed in the flush cycle are not drops.
  assign held = (state == TWO) ? 2'd2 :
                (state == ONE) ? 2'd1 : 2'd0;
  assign drops = {1'b0, held}
               - {2'b0, xfer}
               + {2'b0, accept};
  assign drop_sum = {1'b0, flush_drops}
                  + {14'b0, drops};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cycles <= '0;
      flush_drops  <= '0;
    end else begin
      if (out_valid && !out_ready &&
          stall_cycles != 32'hFFFF_FFFF) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush) begin
        flush_drops <= drop_sum[16] ? 16'hFFFF
                                    : drop_sum[15:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_packer.sv
// Scoreboard bench for pipe_reg_packer.
// Perf checks are compiled only with PIPEREG_PERF_EN.
module tb_pipe_reg_packer;
  import pipe_reg_pkg::*;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic [DATA_W-1:0]    inst = '0;
  logic [DATA_W-1:0]    a_data = '0;
  logic [DATA_W-1:0]    b_data = '0;
  logic [CTRL_W-1:0]    control_data = '0;
  logic [ALUCTRL_W-1:0] alucontrol_data = '0;
  logic [DATA_W-1:0]    pc = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 flush = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [BUNDLE_W-1:0]  dataout;
`ifdef PIPEREG_PERF_EN
  logic [31:0]          stall_cycles;
  logic [15:0]          flush_drops;
`endif

  pipe_reg_packer dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst            (inst),
    .a_data          (a_data),
    .b_data          (b_data),
    .control_data    (control_data),
    .alucontrol_data (alucontrol_data),
    .pc              (pc),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .dataout         (dataout)
`ifdef PIPEREG_PERF_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_drops     (flush_drops)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [BUNDLE_W-1:0] exp_q[$];

  task automatic check(input string name,
                       input logic [BUNDLE_W-1:0] act,
                       input logic [BUNDLE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        check("out_bundle", dataout,
              exp_q.pop_front());
      end
    end
  end

  task automatic send(
    input logic [DATA_W-1:0]    i_inst,
    input logic [DATA_W-1:0]    i_a,
    input logic [DATA_W-1:0]    i_b,
    input logic [CTRL_W-1:0]    i_ctrl,
    input logic [ALUCTRL_W-1:0] i_alu,
    input logic [DATA_W-1:0]    i_pc);
    int n;
    inst            = i_inst;
    a_data          = i_a;
    b_data          = i_b;
    control_data    = i_ctrl;
    alucontrol_data = i_alu;
    pc              = i_pc;
    in_valid        = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 1, 0);
    else exp_q.push_back({i_inst, i_a, i_b,
                          i_ctrl, i_alu, i_pc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("latency_valid", out_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_flush();
    flush    = 1'b1;
    in_valid = 1'b1;
    inst     = 32'hDEAD_BEEF;
    pc       = 32'h0BAD_0BAD;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
  endtask

  initial begin
`ifdef PIPEREG_PERF_EN
    logic [31:0] s0;
    logic [15:0] f0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_dataout", dataout, 0);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_empty", out_valid, 0);

    out_ready = 1'b1;
    send(32'h8C22_0004, 32'h1111_0001,
         32'h2222_0001, 54'h2A, 38'h15,
         32'hBFC0_0000);
    check("inst_field", dataout[219:188],
          32'h8C22_0004);
    check("pc_field", dataout[31:0],
          32'hBFC0_0000);
    for (int k = 1; k < 4; k++) begin
      send(32'h8C22_0004 + k, 32'h1111_0000 + k,
           32'h2222_0000 + k, 54'(k), 38'(k),
           32'hBFC0_0000 + 32'(4 * k));
      check("stream_in_ready", in_ready, 1);
    end
    drain();

    out_ready = 1'b0;
    send(32'hA000_0001, 32'h1, 32'h2, 54'h3,
         38'h4, 32'hBFC0_0100);
    send(32'hA000_0002, 32'h5, 32'h6, 54'h7,
         38'h8, 32'hBFC0_0104);
    check("bp_in_ready_low", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_data", dataout, exp_q[0]);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready_back", in_ready, 1);
    drain();

    out_ready = 1'b0;
    send(32'hB000_0001, 32'h9, 32'hA, 54'hB,
         38'hC, 32'hBFC0_0200);
    send(32'hB000_0002, 32'hD, 32'hE, 54'hF,
         38'h10, 32'hBFC0_0204);
`ifdef PIPEREG_PERF_EN
    f0 = flush_drops;
`endif
    do_flush();
`ifdef PIPEREG_PERF_EN
    check("flush_drops_two",
          flush_drops - f0, 2);
`endif
    out_ready = 1'b1;
    send(32'hC000_0001, 32'h0, 32'h0, 54'h0,
         38'h0, 32'h8000_0180);
    check("post_flush_pc", dataout[31:0],
          32'h8000_0180);
    drain();

    out_ready = 1'b0;
    send(32'hC100_0001, 32'h1, 32'h1, 54'h1,
         38'h1, 32'h8000_0200);
`ifdef PIPEREG_PERF_EN
    f0 = flush_drops;
`endif
    do_flush();
`ifdef PIPEREG_PERF_EN
    check("flush_drops_one_acc",
          flush_drops - f0, 2);
`endif
    out_ready = 1'b1;

    send(32'h0, 32'h0, 32'h0, 54'h1,
         38'h3F_FFFF_FFFF, 32'h0);
    check("map_rtype", dataout[70], 1);
    check("map_alu", dataout[69:32],
          38'h3F_FFFF_FFFF);
    check("map_upper_zero",
          dataout[219:71], 0);
    check("map_pc_zero", dataout[31:0], 0);
    drain();

`ifdef PIPEREG_PERF_EN
    out_ready = 1'b0;
    send(32'hD000_0001, 32'h0, 32'h0, 54'h0,
         38'h0, 32'h8000_0300);
    s0 = stall_cycles;
    repeat (10) @(posedge clk);
    #1;
    check("stall_cycles_10",
          stall_cycles - s0, 10);
    out_ready = 1'b1;
    drain();
`endif

    out_ready = 1'b0;
    send(32'hE000_0001, 32'h3, 32'h3, 54'h3,
         38'h3, 32'h8000_0400);
    send(32'hE000_0002, 32'h4, 32'h4, 54'h4,
         38'h4, 32'h8000_0404);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_data", dataout, 0);
`ifdef PIPEREG_PERF_EN
    check("mid_rst_stall", stall_cycles, 0);
    check("mid_rst_drops", flush_drops, 0);
`endif
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_reg_packer.md
Name: pipe_reg_packer

Overview:
- Packs decode-stage outputs into the 220-bit ID/EX pipeline bundle and holds it for the execute stage.
- Field order, MSB to LSB: inst, A_data, B_data, control_data, alucontrol_data, PC.
- Two-entry skid buffer: full throughput with a registered in_ready. Flush kills all in-flight entries.
- Sits between the decode stage (upstream) and the execute-stage field unpacker (downstream).

Parameters:
- DATA_W, 32, width of inst, A_data, B_data and PC.
- CTRL_W, 54, width of control_data.
- ALUCTRL_W, 38, width of alucontrol_data.
- BUNDLE_W is a localparam, 4*DATA_W+CTRL_W+ALUCTRL_W = 220.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- inst  in  DATA_W  instruction word
- a_data  in  DATA_W  rs operand
- b_data  in  DATA_W  rt operand
- control_data  in  CTRL_W  main decoder control; bit 0 is r_type
- alucontrol_data  in  ALUCTRL_W  funct-decoder control
- pc  in  DATA_W  instruction PC
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  packer can accept
- flush  in  1  discard all held and incoming entries
- out_valid  out  1  dataout valid
- out_ready  in  1  execute stage consumes
- dataout  out  BUNDLE_W  packed bundle: inst[219:188], A[187:156], B[155:124], control[123:70], alucontrol[69:32], PC[31:0]
- stall_cycles  out  32  only with PIPEREG_PERF_EN
- flush_drops  out  16  only with PIPEREG_PERF_EN

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (resetn).
- Reset (resetn=0 at a clk edge):
  - state EMPTY; out_valid=0; in_ready=1; dataout=0.
  - Perf counters are 0.
  - A reset mid-transfer drops all entries without any handshake.
- Handshakes:
  - accept = in_valid & in_ready.
  - xfer = out_valid & out_ready.
  - Latency is 1 cycle: data accepted at edge N is on dataout after edge N.
- Storage:
  - main slot drives dataout directly; out_valid = state != EMPTY.
  - skid slot is used only in state TWO.
  - in_ready is registered: in_ready = (state != TWO).
- State transitions, when flush=0:
  - EMPTY: accept -> load main, go ONE.
  - ONE, accept & xfer: load main with new input, stay ONE.
  - ONE, accept & !xfer: load skid, go TWO.
  - ONE, !accept & xfer: go EMPTY.
  - ONE, neither: hold.
  - TWO: no accept possible. xfer -> main <= skid, go ONE; otherwise hold.
- Stability: while out_valid & !out_ready, dataout and out_valid do not change.
- flush=1 has the highest priority:
  - Next state is EMPTY; out_valid=0; in_ready=1 next cycle.
  - An input accepted in the flush cycle is discarded.
  - An xfer in the flush cycle still counts as consumed downstream.
- dataout is not cleared on flush or on going EMPTY; it keeps its last value and is qualified by out_valid.
- Packing is pure concatenation: no field masking and no sign extension. r_type is not interpreted here.

Optional Feature:
- Macro: PIPEREG_PERF_EN.
- When defined:
  - stall_cycles increments each cycle with out_valid & !out_ready and saturates at 32'hFFFF_FFFF.
  - flush_drops adds the number of valid entries discarded by each flush (0, 1 or 2, plus 1 if an input was accepted that cycle) and saturates at 16'hFFFF.
  - Both counters reset to 0.
- When undefined: both ports and their counters are absent. Datapath timing is unchanged.

Decomposition:
- Package pipe_reg_pkg holds:
  - DATA_W, CTRL_W, ALUCTRL_W, BUNDLE_W.
  - Field LSB offsets: INST_LSB=188, A_LSB=156, B_LSB=124, CTRL_LSB=70, ALUCTRL_LSB=32, PC_LSB=0.
  - State encoding EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
- Sub-module pipe_reg_slot: BUNDLE_W-wide register with load enable and synchronous active-low reset. Instantiated twice (main, skid).

Test Plan:
- Reset: resetn=0 for 2 cycles -> out_valid=0, in_ready=1, dataout=0. Release reset with no input -> state stays EMPTY.
- Streaming with out_ready=1: send inst=0x8C220004, pc=0xBFC00000, then 3 more back-to-back -> each bundle appears 1 cycle later with no bubbles; dataout[219:188]=0x8C220004 and dataout[31:0]=0xBFC00000.
- Backpressure: after 2 accepts with out_ready=0 -> in_ready=0. Raise out_ready -> bundles come out in order. in_ready returns to 1 one cycle after the first xfer, and no data is lost or duplicated.
- Flush in state TWO with in_valid=1 -> next cycle out_valid=0 and in_ready=1. The next accepted bundle (pc=0x80000180) is the first one out. With PIPEREG_PERF_EN, flush_drops=2.
- Field mapping: control_data=54'h1 and alucontrol_data=38'h3F_FFFF_FFFF, all other fields 0 -> dataout[70]=1 and dataout[69:32] all ones.
- Perf (PIPEREG_PERF_EN): hold out_ready=0 with a valid entry for 10 cycles -> stall_cycles=10. Force the counter to 0xFFFFFFFE and stall 3 more cycles -> it reads 0xFFFFFFFF.
